// File: rtl/adxl362_sample_fetch.sv
`default_nettype none
// ============================================================================
// adxl362_sample_fetch : SPI burst reader returning one X/Y/Z sample per trigger
// Rev 1.0
// ============================================================================
module adxl362_sample_fetch #(
   parameter int unsigned CLK_DIV    = 4,
   parameter logic [7:0]  START_ADDR = 8'h0E,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        trigger,
   output logic        sck_o,
   output logic        ncs_o,
   output logic        mosi_o,
   input  logic        miso_i,
   output logic [15:0] sample_x,
   output logic [15:0] sample_y,
   output logic [15:0] sample_z,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic        overrun,
   input  logic        clear_overrun
);

   localparam logic [7:0]  READ_CMD = 8'h0B;
   localparam logic [15:0] TX_WORD  = {READ_CMD, START_ADDR};
   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      SHIFT    = 3'd2,
      CS_HOLD  = 3'd3,
      GAP      = 3'd4
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  cnt;
   logic [5:0]  bit_cnt;
   logic [15:0] tx_sr;
   logic [47:0] rx_sr;
   logic        trigger_q;
   logic        pending;
   logic        tick;
   logic        start;
   logic        sck_rise;
   logic        sck_fall;
   logic        publish;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      tick       = (cnt == DIV_LAST);
      start      = 1'b0;
      sck_rise   = 1'b0;
      sck_fall   = 1'b0;
      publish    = 1'b0;
      case (state)
         IDLE: begin
            if (pending && enable) begin
               start      = 1'b1;
               state_next = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (tick) state_next = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               if (!sck_o) begin
                  sck_rise = 1'b1;
               end else begin
                  sck_fall = 1'b1;
                  if (bit_cnt == 6'd63) state_next = CS_HOLD;
               end
            end
         end
         CS_HOLD: begin
            if (tick) begin
               publish    = 1'b1;
               state_next = GAP;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         bit_cnt      <= '0;
         tx_sr        <= '0;
         rx_sr        <= '0;
         trigger_q    <= 1'b0;
         pending      <= 1'b0;
         sck_o        <= 1'b0;
         ncs_o        <= 1'b1;
         mosi_o       <= 1'b0;
         sample_x     <= '0;
         sample_y     <= '0;
         sample_z     <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         trigger_q <= trigger;
         // A fresh edge wins over the consume so nothing is lost at start-up.
         if (trigger && !trigger_q) pending <= 1'b1;
         else if (start)            pending <= 1'b0;

         if (state_next != state || state == IDLE) cnt <= '0;
         else if (tick && state != GAP)            cnt <= '0;
         else                                      cnt <= cnt + 8'd1;

         if (start) begin
            ncs_o   <= 1'b0;
            mosi_o  <= TX_WORD[15];
            tx_sr   <= {TX_WORD[14:0], 1'b0};
            bit_cnt <= '0;
         end

         if (sck_rise) begin
            sck_o <= 1'b1;
            if (bit_cnt >= 6'd16) rx_sr <= {rx_sr[46:0], miso_i};
         end

         if (sck_fall) begin
            sck_o   <= 1'b0;
            bit_cnt <= bit_cnt + 6'd1;
            mosi_o  <= tx_sr[15];
            tx_sr   <= {tx_sr[14:0], 1'b0};
         end

         // Received byte order is XL, XH, YL, YH, ZL, ZH.
         if (publish) begin
            ncs_o    <= 1'b1;
            sample_x <= {rx_sr[39:32], rx_sr[47:40]};
            sample_y <= {rx_sr[23:16], rx_sr[31:24]};
            sample_z <= {rx_sr[7:0],   rx_sr[15:8]};
         end

         if (publish)                           sample_valid <= 1'b1;
         else if (sample_valid && sample_ready) sample_valid <= 1'b0;

         if (publish && sample_valid && !sample_ready) overrun <= 1'b1;
         else if (clear_overrun)                       overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adxl362_sample_fetch.sv
`default_nettype none
// Bench for adxl362_sample_fetch: two instances (CLK_DIV=4 and 2) against a
// behavioural ADXL362 slave and expectations derived from the sample rules.
module tb_adxl362_sample_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  reset_n, enable, trigger, sample_ready, clear_overrun;
   logic [1:0]  sck, ncs, mosi, miso, valid, busy, overrun;
   logic [15:0] sx [2];
   logic [15:0] sy [2];
   logic [15:0] sz [2];
   logic [63:0] frame [2];
   logic [15:0] ex, ey, ez;
   int          total = 0;
   int          bad   = 0;

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         localparam int DIV = (g == 0) ? 4 : 2;

         adxl362_sample_fetch #(
            .CLK_DIV(DIV), .START_ADDR(8'h0E), .GAP_CYCLES(8)
         ) u_dut (
            .clk(clk), .reset_n(reset_n[g]), .enable(enable[g]), .trigger(trigger[g]),
            .sck_o(sck[g]), .ncs_o(ncs[g]), .mosi_o(mosi[g]), .miso_i(miso[g]),
            .sample_x(sx[g]), .sample_y(sy[g]), .sample_z(sz[g]),
            .sample_valid(valid[g]), .sample_ready(sample_ready[g]),
            .busy(busy[g]), .overrun(overrun[g]), .clear_overrun(clear_overrun[g])
         );

         // ADXL362 slave: shifts out on SCK fall, captures MOSI on SCK rise.
         int          bidx = 0;
         logic [63:0] cap  = '0;
         logic [5:0]  bsel;
         int          sck_edges = 0;
         assign bsel    = 6'(63 - bidx);
         assign miso[g] = (ncs[g] || bidx > 63) ? 1'b0 : frame[g][bsel];
         always @(negedge ncs[g]) begin bidx = 0; cap = '0; end
         always @(posedge sck[g]) begin
            sck_edges = sck_edges + 1;
            if (!ncs[g]) cap = {cap[62:0], mosi[g]};
         end
         always @(negedge sck[g]) if (!ncs[g]) bidx = bidx + 1;

         // Bus monitor: CS timing, SCK phase lengths, MOSI stability.
         int   lowcnt = 0, last_low = 0, highcnt = 0, last_high = 0, txn = 0;
         int   run = 0, high_runs = 0, phase_err = 0, mosi_err = 0, rises = 0;
         logic prev_ncs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, seen_high = 1'b0;
         always @(negedge clk) begin
            if (!ncs[g] && prev_ncs) begin
               txn = txn + 1; last_high = highcnt; lowcnt = 0;
               run = 0; seen_high = 1'b0; rises = 0;
            end
            if (ncs[g] && !prev_ncs) begin last_low = lowcnt; highcnt = 0; end
            if (!ncs[g]) begin
               lowcnt = lowcnt + 1;
               if (sck[g] != prev_sck) begin
                  if (prev_sck) begin
                     high_runs = high_runs + 1;
                     if (run != DIV) phase_err = phase_err + 1;
                     seen_high = 1'b1;
                  end else if (seen_high && run != DIV) begin
                     phase_err = phase_err + 1;
                  end
                  if (sck[g]) rises = rises + 1;
                  run = 1;
               end else begin
                  run = run + 1;
               end
               if (mosi[g] != prev_mosi && sck[g]) mosi_err = mosi_err + 1;
            end else begin
               highcnt = highcnt + 1;
            end
            prev_ncs = ncs[g]; prev_sck = sck[g]; prev_mosi = mosi[g];
         end
      end
   endgenerate

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sext12(input logic [11:0] v);
      return {{4{v[11]}}, v};
   endfunction

   task automatic set_model(input int g, input logic [11:0] x, input logic [11:0] y,
                            input logic [11:0] z);
      ex = sext12(x); ey = sext12(y); ez = sext12(z);
      frame[g] = {16'h0, ex[7:0], ex[15:8], ey[7:0], ey[15:8], ez[7:0], ez[15:8]};
   endtask

   task automatic pulse_trig(input int g);
      trigger[g] = 1'b1;
      @(negedge clk);
      trigger[g] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ncs(input int g, input logic lvl, input int budget, input string tag);
      int n = 0;
      while (ncs[g] !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(ncs[g]), 64'(lvl));
      #1;
   endtask

   task automatic burst(input int g);
      pulse_trig(g);
      wait_ncs(g, 1'b0, 40, "burst_start");
      wait_ncs(g, 1'b1, 2000, "burst_end");
   endtask

   task automatic consume(input int g);
      sample_ready[g] = 1'b1;
      @(negedge clk);
      check("consume_valid", 64'(valid[g]), 64'd0);
      sample_ready[g] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_cap;
      int          n, base, edges;
      exp_cap       = {8'h0B, 8'h0E, 48'h0};
      reset_n       = 2'b00;
      enable        = 2'b11;
      trigger       = 2'b00;
      sample_ready  = 2'b00;
      clear_overrun = 2'b00;
      frame[0]      = '0;
      frame[1]      = '0;
      repeat (3) @(negedge clk);

      check("rst_ncs", 64'(ncs[0]), 64'd1);
      check("rst_sck", 64'(sck[0]), 64'd0);
      check("rst_mosi", 64'(mosi[0]), 64'd0);
      check("rst_x", 64'(sx[0]), 64'd0);
      check("rst_valid", 64'(valid[0]), 64'd0);
      check("rst_busy", 64'(busy[0]), 64'd0);
      check("rst_overrun", 64'(overrun[0]), 64'd0);
      reset_n = 2'b11;
      @(negedge clk);

      // Basic burst with fixed axis values
      set_model(0, 12'h123, 12'hF80, 12'h400);
      pulse_trig(0);
      wait_ncs(0, 1'b0, 40, "s1_start");
      check("s1_busy", 64'(busy[0]), 64'd1);
      wait_ncs(0, 1'b1, 2000, "s1_end");
      check("s1_cmd_bytes", g_dut[0].cap, exp_cap);
      check("s1_cs_len", 64'(g_dut[0].last_low), 64'd520);
      check("s1_x", 64'(sx[0]), 64'h0123);
      check("s1_y", 64'(sy[0]), 64'hFF80);
      check("s1_z", 64'(sz[0]), 64'h0400);
      check("s1_valid", 64'(valid[0]), 64'd1);
      check("s1_overrun", 64'(overrun[0]), 64'd0);
      consume(0);

      // Overwrite with ready held low, then clear and consume
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      burst(0);
      check("s2a_x", 64'(sx[0]), 64'(ex));
      check("s2a_y", 64'(sy[0]), 64'(ey));
      check("s2a_z", 64'(sz[0]), 64'(ez));
      check("s2a_overrun", 64'(overrun[0]), 64'd0);
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      burst(0);
      check("s2b_x", 64'(sx[0]), 64'(ex));
      check("s2b_z", 64'(sz[0]), 64'(ez));
      check("s2b_valid", 64'(valid[0]), 64'd1);
      check("s2b_overrun", 64'(overrun[0]), 64'd1);
      clear_overrun[0] = 1'b1;
      @(negedge clk);
      clear_overrun[0] = 1'b0;
      check("s2_clear", 64'(overrun[0]), 64'd0);
      check("s2_stable_y", 64'(sy[0]), 64'(ey));
      consume(0);

      // Three edges during one transaction yield exactly one more
      sample_ready[0] = 1'b1;
      base = g_dut[0].txn;
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      pulse_trig(0);
      wait_ncs(0, 1'b0, 40, "s3_start");
      repeat (3) begin
         repeat (5) @(negedge clk);
         pulse_trig(0);
      end
      wait_ncs(0, 1'b1, 1000, "s3_end1");
      wait_ncs(0, 1'b0, 40, "s3_restart");
      check("s3_gap_min", 64'(g_dut[0].last_high >= 8), 64'd1);
      wait_ncs(0, 1'b1, 1000, "s3_end2");
      repeat (100) @(negedge clk);
      check("s3_txn_count", 64'(g_dut[0].txn - base), 64'd2);
      check("s3_x", 64'(sx[0]), 64'(ex));
      check("s3_overrun", 64'(overrun[0]), 64'd0);
      sample_ready[0] = 1'b0;

      // Enable low holds the request; enable dropped mid-burst still completes
      enable[0] = 1'b0;
      base  = g_dut[0].txn;
      edges = g_dut[0].sck_edges;
      pulse_trig(0);
      repeat (100) @(negedge clk);
      check("s4_no_txn", 64'(g_dut[0].txn - base), 64'd0);
      check("s4_no_sck", 64'(g_dut[0].sck_edges - edges), 64'd0);
      check("s4_idle", 64'(busy[0]), 64'd0);
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      enable[0] = 1'b1;
      n = 0;
      while (ncs[0] !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("s4_latency", 64'(n <= 2 && ncs[0] === 1'b0), 64'd1);
      repeat (20) @(negedge clk);
      enable[0] = 1'b0;
      wait_ncs(0, 1'b1, 1000, "s4_end");
      check("s4_cs_len", 64'(g_dut[0].last_low), 64'd520);
      check("s4_y", 64'(sy[0]), 64'(ey));
      check("s4_valid", 64'(valid[0]), 64'd1);
      enable[0] = 1'b1;
      consume(0);

      // Asynchronous reset in the middle of SHIFT
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      pulse_trig(0);
      wait_ncs(0, 1'b0, 40, "s5_start");
      n = 0;
      while (g_dut[0].rises < 31 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("s5_reach_bit30", 64'(g_dut[0].rises), 64'd31);
      #2;
      reset_n[0] = 1'b0;
      #1;
      check("s5_async_ncs", 64'(ncs[0]), 64'd1);
      check("s5_async_sck", 64'(sck[0]), 64'd0);
      check("s5_busy", 64'(busy[0]), 64'd0);
      @(negedge clk);
      check("s5_valid", 64'(valid[0]), 64'd0);
      check("s5_x", 64'(sx[0]), 64'd0);
      reset_n[0] = 1'b1;
      @(negedge clk);
      set_model(0, 12'($urandom), 12'($urandom), 12'($urandom));
      burst(0);
      check("s5_cmd_bytes", g_dut[0].cap, exp_cap);
      check("s5_cs_len", 64'(g_dut[0].last_low), 64'd520);
      check("s5_x2", 64'(sx[0]), 64'(ex));
      check("s5_z2", 64'(sz[0]), 64'(ez));
      check("s5_valid2", 64'(valid[0]), 64'd1);
      check("s5_overrun", 64'(overrun[0]), 64'd0);
      check("div4_phase", 64'(g_dut[0].phase_err), 64'd0);
      check("div4_mosi", 64'(g_dut[0].mosi_err), 64'd0);

      // Same transfer on the CLK_DIV=2 instance
      set_model(1, 12'h123, 12'hF80, 12'h400);
      burst(1);
      check("d2_cmd_bytes", g_dut[1].cap, exp_cap);
      check("d2_cs_len", 64'(g_dut[1].last_low), 64'd260);
      check("d2_x", 64'(sx[1]), 64'h0123);
      check("d2_y", 64'(sy[1]), 64'hFF80);
      check("d2_z", 64'(sz[1]), 64'h0400);
      check("d2_valid", 64'(valid[1]), 64'd1);
      check("d2_high_phases", 64'(g_dut[1].high_runs), 64'd64);
      check("d2_phase", 64'(g_dut[1].phase_err), 64'd0);
      check("d2_mosi", 64'(g_dut[1].mosi_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adxl362_sample_fetch.md
Name: adxl362_sample_fetch

Overview:
- SPI master sequencer inside the soc that reads one X/Y/Z sample burst from the ADXL362 accelerometer on each trigger.
- The trigger is normally int1 or a firmware poll strobe.
- It drives sck_o/ncs_o/mosi_o and samples miso_i.
- It assembles three signed 16-bit axis words and presents them to the downstream Wishbone register slave through a 1-deep valid/ready output register.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal values are 2 to 255.
- START_ADDR, 8'h0E, first register of the burst read (XDATA_L).
- GAP_CYCLES, 8, minimum clk cycles ncs_o stays high between transactions.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  allows new transactions to start.
- trigger  input  1  level; a rising edge requests one burst read.
- sck_o  output  1  SPI clock, CPOL=0/CPHA=0.
- ncs_o  output  1  SPI chip select, active low.
- mosi_o  output  1  SPI data out, MSB first.
- miso_i  input  1  SPI data in.
- sample_x  output  16  X axis, {XDATA_H, XDATA_L}.
- sample_y  output  16  Y axis.
- sample_z  output  16  Z axis.
- sample_valid  output  1  sample registers hold an unconsumed sample.
- sample_ready  input  1  consumer accepts the sample when valid&ready.
- busy  output  1  high whenever the FSM is not in IDLE.
- overrun  output  1  sticky flag: an unconsumed sample was overwritten.
- clear_overrun  input  1  one-cycle pulse that clears overrun.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: ncs_o=1, sck_o=0, mosi_o=0, sample_*=0, sample_valid=0, busy=0, overrun=0.
  - Internal: FSM to IDLE, pending trigger cleared.
  - Reset mid-transaction aborts immediately; no partial sample is published.
- Trigger detection:
  - trigger is registered once; a rising edge sets pending.
  - pending is a single bit; extra edges while pending=1 are dropped.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
- IDLE: when pending&enable, clear pending, go to CS_SETUP, drive ncs_o=0 on the next edge, and load mosi_o with bit 7 of 8'h0B.
- CS_SETUP: hold for CLK_DIV cycles with sck_o=0.
- SHIFT: 64 bits = 8 bytes: 8'h0B, START_ADDR, then 6 dummy bytes with mosi_o=0.
  - Per bit: sck_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - miso_i is sampled on the clk edge that raises sck_o.
  - mosi_o updates on the edge that lowers sck_o; the first bit is set up in IDLE.
  - Bit counter 6 bits wide, 0 to 63.
  - Bits 16 to 63 shift into a 48-bit register, MSB-first per byte.
- CS_HOLD: sck_o=0 for CLK_DIV cycles, then ncs_o=1 and go to GAP.
- Sample publish, on the edge that raises ncs_o:
  - Byte order received: XL, XH, YL, YH, ZL, ZH.
  - sample_x={XH,XL}, sample_y={YH,YL}, sample_z={ZH,ZL}; no re-sign-extension, since the device supplies sign bits.
  - sample_valid is set to 1.
- GAP: GAP_CYCLES cycles, then IDLE. busy falls on entry to IDLE.
- Transaction length from ncs_o falling to ncs_o rising = (2+128)*CLK_DIV cycles; 520 at default.
- Handshake:
  - sample_valid clears on the cycle after valid&ready.
  - Sample outputs are stable while valid=1, except on overwrite.
- Overwrite:
  - Publishing while sample_valid=1 and ready=0 overwrites the sample, keeps valid=1, and sets overrun=1.
  - Publishing in the same cycle as valid&ready is a normal hand-off, not an overrun.
- clear_overrun takes effect next cycle. If it coincides with a new overrun event, overrun stays 1.
- enable deasserted mid-transaction: the current burst completes and publishes; pending is held until enable returns.
- trigger edges arriving during a transaction set pending and are serviced after GAP.

Test Plan:
- Pulse trigger, with the ADXL362 model returning X=12'h123, Y=12'hF80 (sign-extended to 16'hFF80), Z=12'h400 -> bus bytes 0B 0E; ncs_o low exactly 520 clk; sample_x=16'h0123, sample_y=16'hFF80, sample_z=16'h0400; sample_valid=1.
- Hold sample_ready=0 and trigger twice -> second sample replaces the first, overrun=1. Pulse clear_overrun -> overrun=0. Raise ready -> valid drops one cycle later.
- Three trigger edges during one transaction -> exactly one further transaction; ncs_o high for at least GAP_CYCLES=8 between them.
- enable=0 with trigger pulse -> no SCK activity. Raise enable 100 cycles later -> transaction starts within 2 cycles.
- Assert reset_n=0 at bit 30 of SHIFT -> ncs_o=1 and sck_o=0 asynchronously; sample_valid stays 0. After release, trigger -> clean full transaction.
- Rerun the first scenario with CLK_DIV=2 and SCK period checker -> SCK high and low phases are each exactly 2 clk; miso sampled at SCK rising; mosi changes only while SCK is low.
